// File: rtl/button_command_decoder.sv
// button_command_decoder: debounces five synchronized user inputs into armed one-cycle command pulses and stable track levels; define RECORD_LONG_PRESS_EN to add record_long_pulse.
module button_command_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned LONG_PRESS_CYCLES = 200000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic sync_play_button,
  input  logic sync_record_button,
  input  logic sync_reset_button,
  input  logic sync_play_track_switch,
  input  logic sync_record_track_switch,
  output logic play_pulse,
  output logic record_pulse,
  output logic clear_pulse,
  output logic play_track,
  output logic record_track
`ifdef RECORD_LONG_PRESS_EN
  ,
  output logic record_long_pulse
`endif
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
    $error("button_command_decoder: DEBOUNCE_CYCLES must be >= 2 and LONG_PRESS_CYCLES > DEBOUNCE_CYCLES");
  end

  // channel order: 0 play, 1 record, 2 clear, 3 play track, 4 record track
  logic [4:0] raw, s_q, s_d;
  logic [CW-1:0] cnt_q [5];
  logic [CW-1:0] cnt_d [5];
  logic [2:0] armed_q, armed_d, rise, fire;
  logic play_q, play_d, rec_q, rec_d, clr_q, clr_d;

  assign raw = {sync_record_track_switch, sync_play_track_switch, sync_reset_button,
                sync_record_button, sync_play_button};

  // debounce every channel, then arm buttons and resolve pulse priority (clear > record > play)
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      s_d[i]   = (raw[i] != s_q[i] && cnt_q[i] == CMAX) ? raw[i] : s_q[i];
      cnt_d[i] = (raw[i] == s_q[i] || cnt_q[i] == CMAX) ? '0 : cnt_q[i] + 1'b1;
    end
    armed_d = armed_q | (~raw[2:0] & ~s_q[2:0]);
    rise    = s_d[2:0] & ~s_q[2:0];
    fire    = rise & armed_q;
    clr_d   = fire[2];
    rec_d   = fire[1] & ~fire[2];
    play_d  = fire[0] & ~fire[1] & ~fire[2];
  end

  // debounce state, arming flags and registered pulses
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_q     <= '0;
      armed_q <= '0;
      play_q  <= 1'b0;
      rec_q   <= 1'b0;
      clr_q   <= 1'b0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
    end else begin
      s_q     <= s_d;
      armed_q <= armed_d;
      play_q  <= play_d;
      rec_q   <= rec_d;
      clr_q   <= clr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign play_pulse   = play_q;
  assign record_pulse = rec_q;
  assign clear_pulse  = clr_q;
  assign play_track   = s_q[3];
  assign record_track = s_q[4];

`ifdef RECORD_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam logic [HW-1:0] LMAX = HW'(LONG_PRESS_CYCLES - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic long_q, long_d;

  // hold counter saturates at LMAX so the long pulse fires once per press
  always_comb begin
    hold_d = !s_q[1] ? '0 : (armed_q[1] && hold_q != LMAX) ? hold_q + 1'b1 : hold_q;
    long_d = hold_d == LMAX && hold_q != LMAX && !fire[2];
  end

  // long-press counter and pulse registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign record_long_pulse = long_q;
`endif
endmodule

// File: tb/tb_button_command_decoder.sv
// tb_button_command_decoder: scoreboard bench for button_command_decoder (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16).
module tb_button_command_decoder;
  localparam int DC = 4;
  localparam int LP = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic play_b = 1'b0, rec_b = 1'b0, clr_b = 1'b0, play_sw = 1'b0, rec_sw = 1'b0;
  logic play_pulse, record_pulse, clear_pulse, play_track, record_track;
  logic lp_w;

  typedef struct {
    logic [3:0] kind;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  localparam logic [3:0] K_PLAY = 4'b0001;
  localparam logic [3:0] K_REC  = 4'b0010;
  localparam logic [3:0] K_CLR  = 4'b0100;
  localparam logic [3:0] K_LONG = 4'b1000;

  button_command_decoder #(.DEBOUNCE_CYCLES(DC), .LONG_PRESS_CYCLES(LP)) dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .sync_play_button         (play_b),
    .sync_record_button       (rec_b),
    .sync_reset_button        (clr_b),
    .sync_play_track_switch   (play_sw),
    .sync_record_track_switch (rec_sw),
    .play_pulse               (play_pulse),
    .record_pulse             (record_pulse),
    .clear_pulse              (clear_pulse),
    .play_track               (play_track),
    .record_track             (record_track)
`ifdef RECORD_LONG_PRESS_EN
    ,
    .record_long_pulse        (lp_w)
`endif
  );

`ifndef RECORD_LONG_PRESS_EN
  assign lp_w = 1'b0;
`endif

  always #5 clock = ~clock;

  task automatic push(input logic [3:0] kind, input int at);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    sbq.push_back(e);
  endtask

  // advance one clock, sample 1 time unit after the edge and score any pulse
  task automatic tick();
    logic [3:0] pv;
    exp_t e;
    @(posedge clock);
    #1;
    cyc++;
    pv = {lp_w, clear_pulse, record_pulse, play_pulse};
    while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
      e = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_pulse cyc=%0d got=none required=%b@%0d", cyc, e.kind, e.cyc);
    end
    if (pv != 4'b0000) begin
      checks++;
      if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got=%b required=none", cyc, pv);
      end else begin
        e = sbq.pop_front();
        if (pv !== e.kind) begin
          errors++;
          $display("FAIL pulse_kind cyc=%0d got=%b required=%b", cyc, pv, e.kind);
        end
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    logic [5:0] ov;
    reset_n = 1'b0;
    ticks(2);
    ov = {lp_w, play_pulse, record_pulse, clear_pulse, play_track, record_track};
    checks++;
    if (ov !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b required=000000", ov);
    end
    reset_n = 1'b1;
    ticks(3);
    ov = {lp_w, play_pulse, record_pulse, clear_pulse, play_track, record_track};
    checks++;
    if (ov !== 6'b0) begin
      errors++;
      $display("FAIL idle_outputs got=%b required=000000", ov);
    end
  endtask

  task automatic test_play_pulse();
    play_b = 1'b1;
    push(K_PLAY, cyc + DC);
    ticks(10);
    play_b = 1'b0;
    ticks(6);
  endtask

  task automatic test_glitch();
    logic [7:0] pat;
    pat = 8'b0111_0111;
    for (int i = 0; i < 8; i++) begin
      rec_b = pat[i];
      tick();
    end
    rec_b = 1'b0;
    ticks(6);
  endtask

  task automatic test_priority();
    play_b = 1'b1;
    rec_b  = 1'b1;
    push(K_REC, cyc + DC);
    ticks(6);
    play_b = 1'b0;
    rec_b  = 1'b0;
    ticks(6);
    play_b = 1'b1;
    rec_b  = 1'b1;
    clr_b  = 1'b1;
    push(K_CLR, cyc + DC);
    ticks(6);
    play_b = 1'b0;
    rec_b  = 1'b0;
    clr_b  = 1'b0;
    ticks(6);
  endtask

  task automatic test_power_on_arm();
    play_b  = 1'b1;
    reset_n = 1'b0;
    ticks(2);
    reset_n = 1'b1;
    ticks(8);
    play_b = 1'b0;
    ticks(5);
    play_b = 1'b1;
    push(K_PLAY, cyc + DC);
    ticks(5);
    play_b = 1'b0;
    ticks(6);
  endtask

  task automatic test_tracks();
    play_sw = 1'b1;
    ticks(DC - 1);
    checks++;
    if (play_track !== 1'b0) begin
      errors++;
      $display("FAIL play_track_early got=%b required=0", play_track);
    end
    tick();
    checks++;
    if (play_track !== 1'b1) begin
      errors++;
      $display("FAIL play_track_rise got=%b required=1", play_track);
    end
    play_sw = 1'b0;
    ticks(DC);
    checks++;
    if (play_track !== 1'b0) begin
      errors++;
      $display("FAIL play_track_fall got=%b required=0", play_track);
    end
    rec_sw = 1'b1;
    ticks(DC - 1);
    checks++;
    if (record_track !== 1'b0) begin
      errors++;
      $display("FAIL record_track_early got=%b required=0", record_track);
    end
    tick();
    checks++;
    if (record_track !== 1'b1) begin
      errors++;
      $display("FAIL record_track_rise got=%b required=1", record_track);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (record_track !== 1'b0) begin
      errors++;
      $display("FAIL record_track_async_clear got=%b required=0", record_track);
    end
    #1;
    reset_n = 1'b1;
    ticks(DC - 1);
    checks++;
    if (record_track !== 1'b0) begin
      errors++;
      $display("FAIL record_track_after_reset_early got=%b required=0", record_track);
    end
    tick();
    checks++;
    if (record_track !== 1'b1) begin
      errors++;
      $display("FAIL record_track_after_reset got=%b required=1", record_track);
    end
    rec_sw = 1'b0;
    ticks(DC);
    rec_sw = 1'b1;
    ticks(2);
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    ticks(DC - 1);
    checks++;
    if (record_track !== 1'b0) begin
      errors++;
      $display("FAIL record_track_counter_cleared got=%b required=0", record_track);
    end
    tick();
    checks++;
    if (record_track !== 1'b1) begin
      errors++;
      $display("FAIL record_track_mid_debounce got=%b required=1", record_track);
    end
    rec_sw = 1'b0;
    ticks(DC + 2);
  endtask

`ifdef RECORD_LONG_PRESS_EN
  task automatic test_long_press();
    rec_b = 1'b1;
    push(K_REC, cyc + DC);
    push(K_LONG, cyc + DC + LP - 1);
    ticks(30);
    rec_b = 1'b0;
    ticks(6);
  endtask
`endif

  initial begin
    test_reset();
    test_play_pulse();
    test_glitch();
    test_priority();
    test_power_on_arm();
    test_tracks();
`ifdef RECORD_LONG_PRESS_EN
    test_long_press();
`endif
    ticks(2);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d required=0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
